// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU op codes, OP-opcode and funct fields, writer state and request payload.
package rv32i_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned INSTR_W  = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
  } rtype_req_t;

  function automatic logic [INSTR_W-1:0] rtype_encode(
    input logic [6:0]       funct7,
    input logic [REG_W-1:0] rs2,
    input logic [REG_W-1:0] rs1,
    input logic [2:0]       funct3,
    input logic [REG_W-1:0] rd
  );
    return {funct7, rs2, rs1, funct3, rd, OPCODE_OP};
  endfunction

endpackage

// File: rtl/rtype_field_encoder.sv
// Combinational ALU-op to funct3/funct7 decode; codes outside the enum are flagged illegal.
module rtype_field_encoder
  import rv32i_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic                illegal
);

  always_comb begin
    funct3  = F3_ADD_SUB;
    funct7  = F7_BASE;
    illegal = 1'b0;
    case (alu_op)
      ALU_ADD:  funct3 = F3_ADD_SUB;
      ALU_SUB:  begin funct3 = F3_ADD_SUB; funct7 = F7_ALT; end
      ALU_SLL:  funct3 = F3_SLL;
      ALU_SRL:  funct3 = F3_SRL_SRA;
      ALU_SRA:  begin funct3 = F3_SRL_SRA; funct7 = F7_ALT; end
      ALU_SLT:  funct3 = F3_SLT;
      ALU_SLTU: funct3 = F3_SLTU;
      ALU_XOR:  funct3 = F3_XOR;
      ALU_OR:   funct3 = F3_OR;
      ALU_AND:  funct3 = F3_AND;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rtype_instr_writer.sv
// Encodes accepted R-type requests and writes them to consecutive instruction-memory words,
// one word per two cycles, stopping when MEM_DEPTH words are written until flush or reset.
module rtype_instr_writer
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   alu_op,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic                         flush,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [$clog2(MEM_DEPTH):0]   count,
  output logic                         full,
  output logic                         err_illegal
);

  localparam int unsigned CW = $clog2(MEM_DEPTH) + 1;

  wr_state_e         state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              in_ready_q, in_ready_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  rtype_req_t        req_c;
  logic [2:0]        funct3_c;
  logic [6:0]        funct7_c;
  logic              illegal_c;

  assign req_c = '{alu_op: alu_op, rd: rd, rs1: rs1, rs2: rs2};

  rtype_field_encoder u_enc (
    .alu_op  (req_c.alu_op),
    .funct3  (funct3_c),
    .funct7  (funct7_c),
    .illegal (illegal_c)
  );

  // Next-state logic; flush overrides everything, including a write in flight.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    in_ready_d  = in_ready_q;
    full_d      = full_q;
    err_d       = 1'b0;

    if (flush) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      in_ready_d = 1'b1;
      full_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (illegal_c) begin
              err_d = 1'b1;
            end else begin
              state_d     = ST_WRITE;
              mem_we_d    = 1'b1;
              in_ready_d  = 1'b0;
              mem_addr_d  = 32'(count_q) << 2;
              mem_wdata_d = rtype_encode(funct7_c, req_c.rs2, req_c.rs1, funct3_c, req_c.rd);
            end
          end
        end
        ST_WRITE: begin
          // The word is counted only once its write cycle completes.
          count_d = count_q + CW'(1);
          if (count_d == CW'(MEM_DEPTH)) begin
            state_d    = ST_FULL;
            full_d     = 1'b1;
            in_ready_d = 1'b0;
          end else begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b1;
          end
        end
        ST_FULL: begin
          in_ready_d = 1'b0;
          full_d     = 1'b1;
        end
        default: begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
          full_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b1;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign count       = count_q;
  assign full        = full_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_rtype_instr_writer.sv
// Self-checking bench for rtype_instr_writer with a transaction-level reference model.
module tb_rtype_instr_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_op;
  logic [4:0]    rd, rs1, rs2;
  logic          flush;
  logic          mem_we;
  logic [31:0]   mem_addr, mem_wdata;
  logic [CW-1:0] count;
  logic          full, err_illegal;

  int checks = 0;
  int errors = 0;

  // Reference model: words written, a write in flight, and the last observable strobe values.
  int          m_count;
  bit          m_pending, m_full, m_we, m_err;
  logic [31:0] m_addr, m_wdata;

  rtype_instr_writer #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .flush(flush),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_encode(input int op, input int d, input int s1, input int s2);
    logic [2:0] f3;
    logic [6:0] f7;
    f7 = 7'h00;
    case (op)
      0: f3 = 3'd0;
      1: begin f3 = 3'd0; f7 = 7'h20; end
      2: f3 = 3'd1;
      3: f3 = 3'd5;
      4: begin f3 = 3'd5; f7 = 7'h20; end
      5: f3 = 3'd2;
      6: f3 = 3'd3;
      7: f3 = 3'd4;
      8: f3 = 3'd6;
      default: f3 = 3'd7;
    endcase
    return {f7, 5'(s2), 5'(s1), f3, 5'(d), 7'h33};
  endfunction

  task automatic model_reset();
    m_count = 0; m_pending = 0; m_full = 0; m_we = 0; m_err = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_step(input bit v, input int op, input int d, input int s1, input int s2,
                            input bit fl);
    m_we = 0;
    m_err = 0;
    if (fl) begin
      m_count = 0; m_pending = 0; m_full = 0;
    end else if (m_pending) begin
      m_count++;
      m_pending = 0;
      m_full = (m_count == DEPTH);
    end else if (!m_full && v) begin
      if (op > 9) begin
        m_err = 1;
      end else begin
        m_we = 1; m_pending = 1;
        m_addr = 32'(4 * m_count);
        m_wdata = ref_encode(op, d, s1, s2);
      end
    end
  endtask

  // Drives one cycle of inputs, advances past the edge and updates the model.
  task automatic drive_cycle(input bit v, input int op, input int d, input int s1, input int s2,
                             input bit fl);
    in_valid = v; alu_op = 4'(op); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); flush = fl;
    @(posedge clk);
    model_step(v, op, d, s1, s2, fl);
    #1;
  endtask

  task automatic do_flush();
    drive_cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    in_valid = 0; alu_op = '0; rd = '0; rs1 = '0; rs2 = '0; flush = 0;
    reset = 1'b1;
    model_reset();
    #3;
    checks++;
    if (mem_we !== 1'b0 || count !== '0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        full !== 1'b0 || err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: we=%b count=%0d addr=%h wdata=%h full=%b err=%b, required all zero",
               mem_we, count, mem_addr, mem_wdata, full, err_illegal);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_add_example();
    drive_cycle(1, 0, 3, 1, 2, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h002081B3 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_write: we=%b addr=%h wdata=%h ready=%b, required 1 00000000 002081b3 0",
               mem_we, mem_addr, mem_wdata, in_ready);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_we !== 1'b0 || count !== CW'(1) || in_ready !== 1'b1 || mem_wdata !== 32'h002081B3) begin
      errors++;
      $display("FAIL add_after: we=%b count=%0d ready=%b wdata=%h, required 0 1 1 002081b3",
               mem_we, count, in_ready, mem_wdata);
    end
  endtask

  task automatic test_sub_sra();
    do_flush();
    drive_cycle(1, 1, 5, 6, 7, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h407302B3) begin
      errors++;
      $display("FAIL sub_write: we=%b addr=%h wdata=%h, required 1 00000000 407302b3",
               mem_we, mem_addr, mem_wdata);
    end
    drive_cycle(1, 4, 31, 30, 29, 0);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL no_accept_in_write: we=%b required 0", mem_we);
    end
    drive_cycle(1, 4, 31, 30, 29, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h41DF5FB3) begin
      errors++;
      $display("FAIL sra_write: we=%b addr=%h wdata=%h, required 1 00000004 41df5fb3",
               mem_we, mem_addr, mem_wdata);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_illegal();
    do_flush();
    drive_cycle(1, 12, 1, 2, 3, 0);
    checks++;
    if (err_illegal !== 1'b1 || mem_we !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse: err=%b we=%b count=%0d ready=%b, required 1 0 0 1",
               err_illegal, mem_we, count, in_ready);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (err_illegal !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL illegal_one_cycle: err=%b count=%0d, required 0 0", err_illegal, count);
    end
  endtask

  task automatic test_full();
    int nw;
    logic [31:0] addrs[$];
    do_flush();
    nw = 0;
    for (int c = 0; c < 14; c++) begin
      drive_cycle(1, c % 10, c + 1, c + 2, c + 3, 0);
      if (mem_we === 1'b1) begin
        nw++;
        addrs.push_back(mem_addr);
      end
    end
    checks++;
    if (nw != 4) begin
      errors++;
      $display("FAIL full_writes: writes=%0d required 4", nw);
    end
    for (int i = 0; i < addrs.size() && i < 4; i++) begin
      checks++;
      if (addrs[i] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL full_addr%0d: addr=%h required %h", i, addrs[i], 32'(4 * i));
      end
    end
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL full_state: full=%b ready=%b count=%0d, required 1 0 %0d",
               full, in_ready, count, DEPTH);
    end
    do_flush();
    checks++;
    if (full !== 1'b0 || in_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL full_flush: full=%b ready=%b count=%0d, required 0 1 0", full, in_ready, count);
    end
  endtask

  task automatic test_flush();
    do_flush();
    drive_cycle(1, 0, 1, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(1, 2, 4, 5, 6, 0);
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (mem_we !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_pending: we=%b count=%0d ready=%b, required 0 0 1", mem_we, count, in_ready);
    end
    drive_cycle(1, 7, 9, 9, 9, 1);
    checks++;
    if (mem_we !== 1'b0 || err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_valid: we=%b err=%b, required 0 0", mem_we, err_illegal);
    end
    drive_cycle(1, 15, 9, 9, 9, 1);
    checks++;
    if (err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_illegal: err=%b required 0", err_illegal);
    end
    drive_cycle(1, 8, 2, 3, 4, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL flush_restart: we=%b addr=%h, required 1 00000000", mem_we, mem_addr);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_write();
    do_flush();
    drive_cycle(1, 0, 1, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(1, 9, 2, 2, 2, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL rst_setup: we=%b addr=%h, required 1 00000004", mem_we, mem_addr);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || count !== '0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_write: we=%b count=%0d addr=%h, required 0 0 00000000",
               mem_we, count, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive_cycle(1, 3, 7, 8, 9, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== ref_encode(3, 7, 8, 9)) begin
      errors++;
      $display("FAIL rst_restart: we=%b addr=%h wdata=%h, required 1 00000000 %h",
               mem_we, mem_addr, mem_wdata, ref_encode(3, 7, 8, 9));
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int op;
    bit v, fl;
    do_flush();
    for (int c = 0; c < 600; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      fl = ($urandom_range(0, 24) == 0);
      drive_cycle(v, op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), fl);
      checks++;
      if (mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_wdata ||
          count !== CW'(m_count) || full !== m_full || err_illegal !== m_err ||
          in_ready !== (!m_pending && !m_full)) begin
        errors++;
        $display("FAIL random_cycle%0d: we=%b addr=%h wdata=%h count=%0d full=%b err=%b ready=%b, required %b %h %h %0d %b %b %b",
                 c, mem_we, mem_addr, mem_wdata, count, full, err_illegal, in_ready,
                 m_we, m_addr, m_wdata, m_count, m_full, m_err, !m_pending && !m_full);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_example();
    test_sub_sra();
    test_illegal();
    test_full();
    test_flush();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
